// File: rtl/draw_engine_responder.sv
// rtl/draw_engine_responder.sv - drawing-engine pixel request responder with one-word read buffer
module draw_engine_responder #(
    parameter int  ADDR_W  = 16,
    parameter int  PIXEL_W = 8,
    parameter int  MEM_W   = 32,
    localparam int LANES   = MEM_W / PIXEL_W,
    localparam int LANE_W  = $clog2(LANES),
    localparam int MADDR_W = ADDR_W - LANE_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               de_req,
    input  logic               de_rnw,
    input  logic [ADDR_W-1:0]  de_addr,
    input  logic [PIXEL_W-1:0] de_wdata,
    output logic               de_ack,
    output logic [PIXEL_W-1:0] de_rdata,
    output logic               busy,
    output logic               mem_req,
    output logic               mem_we,
    output logic [MADDR_W-1:0] mem_addr,
    output logic [LANES-1:0]   mem_be,
    output logic [MEM_W-1:0]   mem_wdata,
    input  logic [MEM_W-1:0]   mem_rdata,
    input  logic               mem_ack
);
    localparam int LSEL_W = (LANE_W > 0) ? LANE_W : 1;

    typedef enum logic [1:0] {IDLE, HIT, MEM, ACK} state_t;

    state_t                        state;
    logic                          rnw_q;
    logic [ADDR_W-1:0]             addr_q;
    logic [PIXEL_W-1:0]            wdata_q;
    logic [LANES-1:0][PIXEL_W-1:0] buf_data;
    logic [MADDR_W-1:0]            buf_tag;
    logic                          buf_valid;

    logic [LANES-1:0][PIXEL_W-1:0] rd_lanes;
    logic [MADDR_W-1:0]            word_in;
    logic [MADDR_W-1:0]            word_q;
    logic [LSEL_W-1:0]             lane_in;
    logic [LSEL_W-1:0]             lane_q;
    logic [LANES-1:0]              be_in;

    assign rd_lanes = mem_rdata;
    assign word_in  = de_addr[ADDR_W-1:LANE_W];
    assign word_q   = addr_q[ADDR_W-1:LANE_W];

    // With a single lane per word there is no lane index in the address.
    generate
        if (LANE_W > 0) begin : g_lane
            assign lane_in = de_addr[LANE_W-1:0];
            assign lane_q  = addr_q[LANE_W-1:0];
        end else begin : g_no_lane
            assign lane_in = '0;
            assign lane_q  = '0;
        end
    endgenerate

    always_comb begin
        be_in          = '0;
        be_in[lane_in] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rnw_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            buf_data  <= '0;
            buf_tag   <= '0;
            buf_valid <= 1'b0;
            de_ack    <= 1'b0;
            de_rdata  <= '0;
            busy      <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (de_req) begin
                        rnw_q   <= de_rnw;
                        addr_q  <= de_addr;
                        wdata_q <= de_wdata;
                        busy    <= 1'b1;
                        if (de_rnw && buf_valid && (buf_tag == word_in)) begin
                            state <= HIT;
                        end else begin
                            state     <= MEM;
                            mem_req   <= 1'b1;
                            mem_we    <= !de_rnw;
                            mem_addr  <= word_in;
                            mem_be    <= de_rnw ? '0 : be_in;
                            mem_wdata <= {LANES{de_wdata}};
                        end
                    end
                end
                HIT: begin
                    de_rdata <= buf_data[lane_q];
                    de_ack   <= 1'b1;
                    state    <= ACK;
                end
                MEM: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        mem_be  <= '0;
                        de_ack  <= 1'b1;
                        state   <= ACK;
                        if (rnw_q) begin
                            buf_data  <= rd_lanes;
                            buf_tag   <= word_q;
                            buf_valid <= 1'b1;
                            de_rdata  <= rd_lanes[lane_q];
                        end else if (buf_valid && (buf_tag == word_q)) begin
                            // Keep the buffered word coherent with the written pixel.
                            buf_data[lane_q] <= wdata_q;
                        end
                    end
                end
                ACK: begin
                    de_ack <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_draw_engine_responder.sv
// tb/tb_draw_engine_responder.sv - scoreboard bench for draw_engine_responder
module tb_draw_engine_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic        de_req;
    logic        de_rnw;
    logic [15:0] de_addr;
    logic [7:0]  de_wdata;
    logic        de_ack;
    logic [7:0]  de_rdata;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [13:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    draw_engine_responder dut (
        .clk(clk), .rst(rst),
        .de_req(de_req), .de_rnw(de_rnw), .de_addr(de_addr), .de_wdata(de_wdata),
        .de_ack(de_ack), .de_rdata(de_rdata), .busy(busy),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] rdata; bit hit; int req_cyc; } ack_exp_t;
    typedef struct { logic [13:0] addr; bit we; logic [3:0] be; logic [31:0] wdata; } mem_exp_t;

    ack_exp_t sb[$];
    mem_exp_t mem_exp[$];

    logic [3:0][7:0] gmem [0:16383];
    logic [3:0][7:0] mbuf;
    logic [13:0]     mtag;
    bit              mv;
    logic [31:0]     last_rd;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int mem_lat = 3;
    bit mem_auto = 1'b1;
    int bursts  = 0;
    int n_acks  = 0;
    int last_mack_cyc = 0;
    int kick_req = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory responder: checks each new access against the expected queue and acks after mem_lat cycles.
    initial begin : responder
        mem_exp_t m;
        int kick_done;
        kick_done = 0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (kick_req != kick_done) begin
                kick_done = kick_req;
                mem_ack   = 1'b1;
                mem_rdata = 32'hFFFF_FFFF;
                @(negedge clk);
                mem_ack = 1'b0;
            end else if (mem_auto && mem_req) begin
                bursts++;
                if (mem_exp.size() == 0) begin
                    check("mem_unexpected", 32'd1, 32'd0);
                end else begin
                    m = mem_exp.pop_front();
                    check("mem_addr", 32'(mem_addr), 32'(m.addr));
                    check("mem_we", 32'(mem_we), 32'(m.we));
                    check("mem_be", 32'(mem_be), 32'(m.be));
                    if (m.we) check("mem_wdata", mem_wdata, m.wdata);
                end
                repeat (mem_lat) @(negedge clk);
                check("mem_req_held", 32'(mem_req), 32'd1);
                mem_ack       = 1'b1;
                mem_rdata     = gmem[mem_addr];
                last_mack_cyc = cyc;
                @(negedge clk);
                mem_ack = 1'b0;
                check("mem_req_drop", 32'(mem_req), 32'd0);
            end
        end
    end

    // Ack monitor: pops the scoreboard on every de_ack pulse.
    initial begin : monitor
        ack_exp_t e;
        bit prev_ack;
        prev_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (de_ack) begin
                n_acks++;
                check("ack_pulse", 32'(prev_ack), 32'd0);
                check("busy_at_ack", 32'(busy), 32'd1);
                if (sb.size() == 0) begin
                    check("spurious_ack", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("de_rdata", 32'(de_rdata), e.rdata);
                    check(e.hit ? "hit_latency" : "miss_latency", cyc,
                          e.hit ? e.req_cyc + 2 : last_mack_cyc + 1);
                end
            end
            prev_ack = de_ack;
        end
    end

    task automatic do_req(input bit rnw, input logic [15:0] addr, input logic [7:0] wd, input bit hold);
        ack_exp_t a;
        mem_exp_t m;
        logic [13:0] w;
        logic [1:0]  ln;
        logic [3:0]  be;
        bit got;
        w  = addr[15:2];
        ln = addr[1:0];
        @(posedge clk); #1;
        de_req = 1'b1; de_rnw = rnw; de_addr = addr; de_wdata = wd;
        a.req_cyc = cyc;
        if (rnw && mv && mtag == w) begin
            a.hit   = 1'b1;
            last_rd = {24'd0, mbuf[ln]};
        end else begin
            a.hit = 1'b0;
            be = '0;
            if (!rnw) be[ln] = 1'b1;
            m.addr = w; m.we = !rnw; m.be = be; m.wdata = {4{wd}};
            mem_exp.push_back(m);
            if (rnw) begin
                mbuf = gmem[w]; mtag = w; mv = 1'b1;
                last_rd = {24'd0, mbuf[ln]};
            end else begin
                gmem[w][ln] = wd;
                if (mv && mtag == w) mbuf[ln] = wd;
            end
        end
        a.rdata = last_rd;
        sb.push_back(a);
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (de_ack) got = 1'b1;
        end
        if (!got) check("ack_timeout", 32'd0, 32'd1);
        if (!hold) begin
            @(posedge clk); #1;
            de_req = 1'b0;
        end
    endtask

    initial begin : main
        int b0;
        int a0;
        for (int i = 0; i < 16384; i++) gmem[i] = '0;
        gmem[14'h0001] = 32'hDDCC_BBAA;
        gmem[14'h0041] = 32'h4433_2211;
        mbuf = '0; mtag = '0; mv = 1'b0; last_rd = '0;
        rst = 1'b1; de_req = 1'b0; de_rnw = 1'b0; de_addr = '0; de_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_de_ack", 32'(de_ack), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_be", 32'(mem_be), 32'd0);
        check("rst_de_rdata", 32'(de_rdata), 32'd0);

        mem_lat = 3;
        do_req(1'b1, 16'h0005, 8'h00, 1'b0);
        b0 = bursts;
        do_req(1'b1, 16'h0006, 8'h00, 1'b0);
        check("hit_no_mem", bursts, b0);
        do_req(1'b0, 16'h0007, 8'h5A, 1'b0);
        b0 = bursts;
        do_req(1'b1, 16'h0007, 8'h00, 1'b0);
        check("wr_then_hit_no_mem", bursts, b0);
        do_req(1'b1, 16'h0104, 8'h00, 1'b0);
        b0 = bursts;
        do_req(1'b1, 16'h0005, 8'h00, 1'b0);
        check("tag_change_miss", bursts, b0 + 1);

        // Reset while the memory access is outstanding, then a stale mem_ack.
        mem_auto = 1'b0;
        @(posedge clk); #1;
        de_req = 1'b1; de_rnw = 1'b1; de_addr = 16'h0200;
        @(posedge clk); #1;
        de_req = 1'b0;
        @(negedge clk);
        check("rst_pre_mem_req", 32'(mem_req), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        kick_req++;
        repeat (4) begin
            @(negedge clk);
            check("rst_mid_no_ack", 32'(de_ack), 32'd0);
            check("rst_mid_busy", 32'(busy), 32'd0);
            check("rst_mid_mem_req", 32'(mem_req), 32'd0);
        end
        mv = 1'b0; last_rd = '0; mem_auto = 1'b1;
        b0 = bursts;
        do_req(1'b1, 16'h0005, 8'h00, 1'b0);
        check("post_rst_miss", bursts, b0 + 1);

        mem_lat = 1;
        b0 = bursts;
        a0 = n_acks;
        do_req(1'b0, 16'h0010, 8'h11, 1'b1);
        do_req(1'b0, 16'h0011, 8'h22, 1'b1);
        do_req(1'b0, 16'h0012, 8'h33, 1'b0);
        check("burst_mem_reqs", bursts, b0 + 3);
        check("burst_acks", n_acks, a0 + 3);
        do_req(1'b1, 16'h0012, 8'h00, 1'b0);

        repeat (5) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        check("mem_exp_empty", mem_exp.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/draw_engine_responder.md
Name: draw_engine_responder

Overview:
- Responder end of the drawing-engine request/acknowledge interface that the edge detector drives through intial_de_req / intial_de_ack.
- Accepts single-pixel read or write requests and converts each into a word-wide access on the framebuffer memory port, which has variable latency.
- Returns a one-cycle de_ack when the access completes.
- Holds a one-word read buffer so that repeated reads of neighbouring pixels do not go to memory.

Parameters:
- ADDR_W, 16: pixel address width (pixel index into framebuffer).
- PIXEL_W, 8: pixel width in bits.
- MEM_W, 32: memory word width; MEM_W/PIXEL_W (LANES) must be a power of two ≥1.
- Derived, not overridable: LANE_W = log2(LANES); MADDR_W = ADDR_W − LANE_W.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  synchronous active-high reset.
- de_req  in  1  request from the drawing client; de_rnw, de_addr and de_wdata are valid while it is high.
- de_rnw  in  1  1 = read pixel, 0 = write pixel.
- de_addr  in  ADDR_W  pixel index.
- de_wdata  in  PIXEL_W  write pixel value.
- de_ack  out  1  one-cycle completion pulse.
- de_rdata  out  PIXEL_W  read pixel; valid in the de_ack cycle and held until the next read completes.
- busy  out  1  high from the acceptance cycle until the ack cycle, inclusive.
- mem_req  out  1  memory access request.
- mem_we  out  1  write enable.
- mem_addr  out  MADDR_W  word address = de_addr[ADDR_W-1:LANE_W].
- mem_be  out  LANES  byte-lane enables (writes only).
- mem_wdata  out  MEM_W  de_wdata replicated across all lanes.
- mem_rdata  in  MEM_W  read word; valid in the mem_ack cycle.
- mem_ack  in  1  memory completion, single-cycle.

Behaviour:
- Reset (synchronous, rst high at a clock edge):
  - state := IDLE; buffer valid := 0.
  - de_ack, busy, mem_req, mem_we = 0; mem_be = 0; de_rdata = 0.
  - Reset mid-transaction abandons it: no de_ack is issued, and a mem_ack arriving after reset is ignored.
- FSM states: IDLE, HIT, MEM, ACK.
- IDLE:
  - de_req sampled high: latch rnw, addr, wdata; set busy.
  - Read with buffer valid and tag == word address → HIT.
  - Otherwise → MEM.
- HIT:
  - de_rdata := buffered lane de_addr[LANE_W-1:0].
  - → ACK.
  - Hit latency: de_req sampled at edge N, de_ack high in cycle N+2.
- MEM:
  - mem_req=1; mem_addr, mem_we=!rnw, mem_be and mem_wdata are driven from the latched request and held stable until mem_ack.
  - For writes, mem_be = one-hot of the lane index.
  - When mem_ack is sampled high:
    - Read: load buffer := mem_rdata, tag := word address, valid := 1, de_rdata := selected lane.
    - Write: if the buffer is valid and the tag matches, update only the written lane in the buffer (write-through coherence).
    - Then → ACK.
  - mem_req drops in the cycle after mem_ack is sampled.
  - Miss latency: de_ack in cycle M+1, where M is the cycle in which mem_ack is high.
- ACK:
  - de_ack=1 for exactly one cycle; busy drops at the end of this cycle.
  - → IDLE.
- Back-to-back requests:
  - The client may hold de_req high across de_ack to issue the next request.
  - de_req is not sampled in ACK, so the next request is accepted in IDLE one cycle later: minimum 1 idle cycle between transactions.
- Other rules:
  - de_req changes while busy are ignored, because the inputs are latched at acceptance.
  - mem_ack while not in MEM is ignored.
  - Lane selection: lane k covers bits [(k+1)·PIXEL_W−1 : k·PIXEL_W]; no wrap or overflow arithmetic is applied to addresses.

Test Plan:
1. Reset, then read addr 0x0005 with memory returning 0xDDCCBBAA after 3 cycles → mem_addr=0x0001, mem_we=0, then de_rdata=0xBB with one de_ack pulse the cycle after mem_ack.
2. Then read addr 0x0006 → no mem_req (hit), de_rdata=0xCC, de_ack 2 cycles after de_req is sampled.
3. Write 0x5A to 0x0007 → mem_we=1, mem_be=4'b1000, mem_wdata=0x5A5A5A5A. A following read of 0x0007 hits and returns 0x5A.
4. Read 0x0104 → mem_addr=0x0041 (miss, new tag). A later read of 0x0005 misses and goes to memory again.
5. Assert rst while in MEM, then pulse mem_ack the next cycle → no de_ack, busy=0, mem_req=0. A next read of 0x0005 misses (buffer invalidated).
6. Hold de_req high for 3 writes, each with mem_ack after 1 cycle → exactly 3 de_ack pulses, 3 mem_req bursts, and at least one de_ack-low cycle between pulses.
